// File: rtl/spm_pkg.sv
// Shared definitions for the serial-parallel multiplier.
//   state_t        : controller states (IDLE, RUN)
//   cnt_w()        : width of the bit counter for a given operand width
//   SPM_MAX_WIDTH  : largest supported operand width
package spm_pkg;

  localparam int SPM_MAX_WIDTH = 64;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // The counter must hold 0 .. 2*width-1, with one spare bit.
  function automatic int cnt_w(input int width);
    return $clog2(2 * width) + 1;
  endfunction

endpackage

// File: rtl/spm_seq_if.sv
// Handshake and result bundle for spm_seq.
//   start/mc/mp/tc_mode : request and operands (driven by the requester)
//   ready/busy          : controller status
//   p/p_valid           : serial product, LSB first
//   done/prod           : completion pulse and parallel product
// Modports: master = requester side, slave = multiplier side.
interface spm_seq_if #(
  parameter int WIDTH = 32
);

  logic               start;
  logic [WIDTH-1:0]   mc;
  logic [WIDTH-1:0]   mp;
  logic               tc_mode;
  logic               ready;
  logic               busy;
  logic               p;
  logic               p_valid;
  logic               done;
  logic [2*WIDTH-1:0] prod;

  modport master (
    output start, mc, mp, tc_mode,
    input  ready, busy, p, p_valid, done, prod
  );

  modport slave (
    input  start, mc, mp, tc_mode,
    output ready, busy, p, p_valid, done, prod
  );

endinterface

// File: rtl/spm_csa_slice.sv
// One-bit carry-save cell of the serial-parallel multiplier.
//   clk, rst (sync, active-low), clr (sync clear of both registers)
//   a       : multiplicand bit
//   b       : current serial multiplier bit
//   sin     : sum register of the slice above
//   msb_sub : subtract the partial product instead of adding it
//   sum     : registered sum bit, handed to the slice below
//   carry   : registered carry (or borrow) fed back into this slice
module spm_csa_slice (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic a,
  input  logic b,
  input  logic sin,
  input  logic msb_sub,
  output logic sum,
  output logic carry
);

  logic pp;

  assign pp = a & b;

  // Add form:      sum + 2*carry = sin + pp + carry
  // Subtract form: sum - 2*carry = sin - pp - carry  (carry holds a borrow)
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      sum   <= 1'b0;
      carry <= 1'b0;
    end else begin
      sum <= pp ^ sin ^ carry;
      if (msb_sub) carry <= (pp & carry) | (~sin & (pp | carry));
      else         carry <= (pp & carry) | (sin & (pp | carry));
    end
  end

endmodule

// File: rtl/spm_seq.sv
// Parametrised serial-parallel multiplier, unsigned or two's-complement.
//   clk, rst (sync, active-low)
//   bus : spm_seq_if slave port. Operands are taken on a start while ready,
//         the 2*WIDTH-bit product streams out on p/p_valid LSB first and is
//         also presented on prod together with a one-cycle done pulse.
module spm_seq
  import spm_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = cnt_w(WIDTH)
) (
  input  logic     clk,
  input  logic     rst,
  spm_seq_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(2 * WIDTH - 1);

  generate
    if (WIDTH < 2 || WIDTH > SPM_MAX_WIDTH) begin : g_bad_width
      $error("spm_seq: WIDTH out of range");
    end
  endgenerate

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] mc_l;
  logic [WIDTH-1:0] mp_l;
  logic             tc_l;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] carry;
  logic [WIDTH:0]   sum_ext;
  logic             y;
  logic             clr;
  logic             bit0_next;

  // mp_l is shifted right every run cycle, so bit 0 is always the current
  // serial bit; the fill value supplies zero or sign extension once the
  // real multiplier bits are used up.
  assign y       = mp_l[0];
  assign clr     = (state != RUN);
  assign sum_ext = {1'b0, sum};

  // Same equation slice 0 registers; lets prod complete on the edge that
  // produces the last serial bit instead of one cycle later.
  assign bit0_next = (mc_l[0] & y) ^ sum[1] ^ carry[0];

  assign bus.p = sum[0];

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    spm_csa_slice u_slice (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .a       (mc_l[i]),
      .b       (y),
      .sin     (sum_ext[i+1]),
      .msb_sub (tc_l & (i == WIDTH - 1)),
      .sum     (sum[i]),
      .carry   (carry[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      mc_l        <= '0;
      mp_l        <= '0;
      tc_l        <= 1'b0;
      bus.prod    <= '0;
      bus.ready   <= 1'b1;
      bus.busy    <= 1'b0;
      bus.p_valid <= 1'b0;
      bus.done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.p_valid <= 1'b0;
          bus.done    <= 1'b0;
          if (bus.start) begin
            mc_l      <= bus.mc;
            mp_l      <= bus.mp;
            tc_l      <= bus.tc_mode;
            cnt       <= '0;
            bus.prod  <= '0;
            bus.ready <= 1'b0;
            bus.busy  <= 1'b1;
            state     <= RUN;
          end else begin
            bus.ready <= 1'b1;
            bus.busy  <= 1'b0;
          end
        end
        RUN: begin
          mp_l        <= {tc_l & mp_l[WIDTH-1], mp_l[WIDTH-1:1]};
          cnt         <= cnt + CNT_W'(1);
          bus.prod    <= {bit0_next, bus.prod[2*WIDTH-1:1]};
          bus.p_valid <= 1'b1;
          // Leaving RUN here makes the done cycle an IDLE cycle, so a new
          // start is accepted straight away.
          if (cnt == LAST) begin
            bus.ready <= 1'b1;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spm_seq.sv
module tb_spm_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst8;
  logic rst32;

  spm_seq_if #(.WIDTH(8))  bus8 ();
  spm_seq_if #(.WIDTH(32)) bus32 ();

  spm_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst8),  .bus(bus8));
  spm_seq #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst32), .bus(bus32));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0]  mc;
    logic [7:0]  mp;
    logic        tc;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference: exact product from plain integer arithmetic.
  function automatic logic [63:0] ref32(input logic [31:0] a, input logic [31:0] b, input logic tc);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    if (tc) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return sa * sb;
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Issue one WIDTH=8 operation from a negedge and observe 19 cycles.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic tc,
                      output logic [15:0] prodv, output logic [15:0] stream,
                      output int nv, output int nd, output int done_k,
                      output logic rdy_d, output int nv_d);
    bus8.start = 1'b1; bus8.mc = a; bus8.mp = b; bus8.tc_mode = tc;
    step();
    bus8.start = 1'b0;
    bus8.mc = 8'($urandom); bus8.mp = 8'($urandom); bus8.tc_mode = 1'($urandom);
    nv = 0; nd = 0; stream = '0; prodv = '0; done_k = -1; rdy_d = 1'b0; nv_d = -1;
    for (int k = 1; k <= 19; k++) begin
      step();
      if (bus8.p_valid) begin
        if (nv < 16) stream[nv] = bus8.p;
        nv++;
      end
      if (bus8.done) begin
        nd++; prodv = bus8.prod; done_k = k; rdy_d = bus8.ready; nv_d = nv;
      end
    end
  endtask

  task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic tc,
                       output logic [63:0] prodv, output logic [63:0] stream,
                       output int nv, output int nd, output int done_k);
    bus32.start = 1'b1; bus32.mc = a; bus32.mp = b; bus32.tc_mode = tc;
    step();
    bus32.start = 1'b0; bus32.mc = $urandom; bus32.mp = $urandom;
    nv = 0; nd = 0; stream = '0; prodv = '0; done_k = -1;
    for (int k = 1; k <= 66; k++) begin
      step();
      if (bus32.p_valid) begin
        if (nv < 64) stream[nv] = bus32.p;
        nv++;
      end
      if (bus32.done) begin
        nd++; prodv = bus32.prod; done_k = k;
      end
    end
  endtask

  initial begin
    logic [15:0] pv8, st8;
    logic [63:0] pv32, st32, e32;
    logic [31:0] ra, rb;
    logic        rtc, rdy;
    int          nv, nd, dk, nvd;

    tbl[0] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    tbl[1] = '{8'h80, 8'h7F, 1'b1, 16'hC080};
    tbl[2] = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
    tbl[3] = '{8'h80, 8'h7F, 1'b0, 16'h3F80};
    tbl[4] = '{8'h7F, 8'h7F, 1'b1, 16'h3F01};
    tbl[5] = '{8'h80, 8'h80, 1'b1, 16'h4000};
    tbl[6] = '{8'h00, 8'hFF, 1'b0, 16'h0000};
    tbl[7] = '{8'h01, 8'hFF, 1'b1, 16'hFFFF};
    tbl[8] = '{8'h03, 8'h05, 1'b0, 16'h000F};
    tbl[9] = '{8'hFF, 8'h01, 1'b1, 16'hFFFF};

    rst8 = 1'b0; rst32 = 1'b0;
    bus8.start = 1'b0;  bus8.mc = '0;  bus8.mp = '0;  bus8.tc_mode = 1'b0;
    bus32.start = 1'b0; bus32.mc = '0; bus32.mp = '0; bus32.tc_mode = 1'b0;
    @(negedge clk);
    step(); step();
    rst8 = 1'b1; rst32 = 1'b1;
    step();

    chk("rst_ready",   64'(bus8.ready),   64'd1);
    chk("rst_busy",    64'(bus8.busy),    64'd0);
    chk("rst_p",       64'(bus8.p),       64'd0);
    chk("rst_p_valid", 64'(bus8.p_valid), 64'd0);
    chk("rst_done",    64'(bus8.done),    64'd0);
    chk("rst_prod",    64'(bus8.prod),    64'd0);
    chk("rst32_ready", 64'(bus32.ready),  64'd1);
    chk("rst32_prod",  bus32.prod,        64'd0);

    // Table of single operations at WIDTH=8.
    for (int i = 0; i < 10; i++) begin
      run8(tbl[i].mc, tbl[i].mp, tbl[i].tc, pv8, st8, nv, nd, dk, rdy, nvd);
      chk($sformatf("tbl%0d_prod", i),   64'(pv8), 64'(tbl[i].exp));
      chk($sformatf("tbl%0d_stream", i), 64'(st8), 64'(tbl[i].exp));
      chk($sformatf("tbl%0d_nvalid", i), 64'(nv),  64'd16);
      chk($sformatf("tbl%0d_ndone", i),  64'(nd),  64'd1);
      chk($sformatf("tbl%0d_done_cyc", i), 64'(dk), 64'd16);
      chk($sformatf("tbl%0d_ready_at_done", i), 64'(rdy), 64'd1);
      chk($sformatf("tbl%0d_last_valid_at_done", i), 64'(nvd), 64'd16);
    end

    // Back-to-back: start stays high through the first run with new operands.
    bus8.start = 1'b1; bus8.mc = 8'h12; bus8.mp = 8'h34; bus8.tc_mode = 1'b0;
    step();
    bus8.mc = 8'h03; bus8.mp = 8'h05;
    dk = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (bus8.done) begin
        dk = k;
        break;
      end
    end
    chk("b2b_first_done_cyc", 64'(dk), 64'd16);
    chk("b2b_first_prod",     64'(bus8.prod),  64'h03A8);
    chk("b2b_first_ready",    64'(bus8.ready), 64'd1);
    step();
    bus8.start = 1'b0;
    chk("b2b_second_busy",  64'(bus8.busy),  64'd1);
    chk("b2b_second_ready", 64'(bus8.ready), 64'd0);
    chk("b2b_second_prod_clr", 64'(bus8.prod), 64'd0);
    dk = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (bus8.done) begin
        dk = k;
        break;
      end
    end
    chk("b2b_second_done_cyc", 64'(dk), 64'd16);
    chk("b2b_second_prod", 64'(bus8.prod), 64'h000F);
    step(); step();

    // Start pulsed mid-run with different operands must be ignored.
    bus8.start = 1'b1; bus8.mc = 8'hA5; bus8.mp = 8'h3C; bus8.tc_mode = 1'b0;
    step();
    bus8.start = 1'b0;
    nd = 0; dk = -1; pv8 = '0;
    for (int k = 1; k <= 19; k++) begin
      step();
      if (k == 4) begin
        chk("ign_busy",  64'(bus8.busy),  64'd1);
        chk("ign_ready", 64'(bus8.ready), 64'd0);
        bus8.start = 1'b1; bus8.mc = 8'hFF; bus8.mp = 8'hFF; bus8.tc_mode = 1'b1;
      end
      if (k == 5) bus8.start = 1'b0;
      if (bus8.done) begin
        nd++; dk = k; pv8 = bus8.prod;
      end
    end
    chk("ign_prod",     64'(pv8), 64'h26AC);
    chk("ign_ndone",    64'(nd),  64'd1);
    chk("ign_done_cyc", 64'(dk),  64'd16);

    // Reset at edge 7 of a run aborts it.
    bus8.start = 1'b1; bus8.mc = 8'hFF; bus8.mp = 8'hFF; bus8.tc_mode = 1'b0;
    step();
    bus8.start = 1'b0;
    for (int k = 1; k <= 6; k++) step();
    rst8 = 1'b0;
    step();
    rst8 = 1'b1;
    chk("mrst_ready",   64'(bus8.ready),   64'd1);
    chk("mrst_busy",    64'(bus8.busy),    64'd0);
    chk("mrst_p_valid", 64'(bus8.p_valid), 64'd0);
    chk("mrst_done",    64'(bus8.done),    64'd0);
    chk("mrst_prod",    64'(bus8.prod),    64'd0);
    nd = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (bus8.done) nd++;
    end
    chk("mrst_no_done", 64'(nd), 64'd0);

    // Randomized WIDTH=32 runs, both modes, against the reference model.
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rb = $urandom; rtc = 1'(i & 1);
      if (i % 50 == 2) ra = 32'h8000_0000;
      if (i % 50 == 3) rb = 32'hFFFF_FFFF;
      e32 = ref32(ra, rb, rtc);
      run32(ra, rb, rtc, pv32, st32, nv, nd, dk);
      chk($sformatf("rnd%0d_prod a=%h b=%h tc=%0d", i, ra, rb, rtc), pv32, e32);
      chk($sformatf("rnd%0d_stream", i), st32, e32);
      chk($sformatf("rnd%0d_nvalid", i), 64'(nv), 64'd64);
      chk($sformatf("rnd%0d_ndone", i),  64'(nd), 64'd1);
      chk($sformatf("rnd%0d_done_cyc", i), 64'(dk), 64'd64);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spm_seq.md
Name: spm_seq

Overview:
- Parametrised successor to the fixed serial-parallel multiplier (spm) built from per-bit carry-save slices.
- Takes two WIDTH-bit operands through a ready/start handshake and serialises the multiplier internally through a WIDTH-slice CSA array.
- Streams the 2*WIDTH-bit product LSB-first and also presents it in parallel with a done pulse.
- Adds a signed (two's-complement) mode and back-to-back operation; the original block has neither.

Parameters:
- WIDTH, 32, operand width in bits; legal range 2..64.
- CNT_W, $clog2(2*WIDTH)+1, bit-counter width (derived; not overridden).

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  request; accepted only when ready=1.
- mc  in  WIDTH  multiplicand (parallel operand); sampled on the accepting edge.
- mp  in  WIDTH  multiplier (serialised internally); sampled on the accepting edge.
- tc_mode  in  1  1 = signed operands, 0 = unsigned; sampled on the accepting edge.
- ready  out  1  block can accept start.
- busy  out  1  operation in progress.
- p  out  1  serial product bit, LSB first.
- p_valid  out  1  p holds a product bit.
- done  out  1  one-cycle pulse; prod is valid.
- prod  out  2*WIDTH  parallel product; held until the next acceptance.

Behaviour:
- Reset: while rst=0 at an edge, the block goes to IDLE and clears all slice sum/carry registers, latched operands, counter and prod. After reset: ready=1, busy=0, p=0, p_valid=0, done=0, prod=0.
- States: IDLE, RUN.
  - IDLE: ready=1, busy=0. start=1 at an edge (edge 0) latches mc, mp and tc_mode, clears all slices, sets cnt=0, and goes to RUN.
  - RUN: ready=0 except in the final cycle (see back-to-back), busy=1. Each edge feeds the serial bit y=mp_l[cnt] for cnt<WIDTH, otherwise (tc_mode_l ? mp_l[WIDTH-1] : 0). Each edge also advances all slices and increments cnt.
  - RUN at edge 2*WIDTH: goes to IDLE.
- Slice rule for slice i: inputs a=mc_l[i] & y, plus the sum from slice i+1. The MSB slice takes 0 from above; in signed mode it uses the subtract form so mc's MSB weight is negative. Each slice holds registered sum and carry. p is the slice-0 sum register.
- Output timing (edge 0 = accepting edge):
  - p_valid=1 in the 2*WIDTH cycles following edges 1..2*WIDTH; the bit index equals the count of earlier p_valid cycles.
  - prod is shifted in from p, LSB first.
  - done=1 and prod final in the cycle after edge 2*WIDTH, which is the same cycle as the last p_valid.
- Result: unsigned mode, prod = mc*mp. Signed mode, prod = signed(mc)*signed(mp) as 2*WIDTH-bit two's complement. The result is exact; no overflow is possible.
- Back-to-back: ready=1 during the done cycle. A start in that cycle is accepted at the next edge with no idle gap. prod then clears and the new run begins.
- start while busy (other than the done cycle) is ignored; operands are not re-sampled.
- Reset mid-operation: the run is aborted. There is no done and no partial prod; the reset values above apply at the next cycle.
- Operand inputs are don't-care when start=0 or ready=0.

Decomposition:
- Shared package spm_pkg holds:
  - the state enum (IDLE, RUN);
  - the function cnt_w(width);
  - localparam SPM_MAX_WIDTH=64.
- One sub-module, spm_csa_slice: a 1-bit carry-save cell.
  - Ports: clk, rst, clr, a, b, sin, msb_sub.
  - Outputs: registered sum and carry.
  - Instantiated WIDTH times by a generate loop.
- The top-level holds the FSM, counter, y mux, operand latches and prod shifter.

Test Plan:
- WIDTH=8, unsigned, mc=0xFF, mp=0xFF, start at edge 0 -> 16 p_valid cycles, p sequence LSB-first = 0xFE01; done and prod=0xFE01 after edge 16; ready=1 in that cycle.
- WIDTH=8, signed: mc=0x80 (-128), mp=0x7F -> prod=0xC080. Then mc=0xFF, mp=0xFF -> prod=0x0001.
- Back-to-back: start held high through the done cycle with new operands 3*5 -> second run starts at the next edge, prod=0x000F, no idle cycle; first prod is intact in its done cycle.
- start pulsed at edge 5 of a run with different operands -> ignored; the original product completes unchanged.
- rst=0 at edge 7 of a WIDTH=8 run -> next cycle ready=1, busy=0, p_valid=0, prod=0; no done ever asserted for that run.
- WIDTH=32: 1000 random operands in both modes against a reference model. Check 64 p_valid cycles per run, a single done pulse, and prod equal to the serial stream.
